// File: rtl/scene_pkg.sv
// Shared types and helpers for the frame-rate scene sequencer.
// Holds the phase encoding, the offset type and the lane-to-offset mapping.
package scene_pkg;

   typedef enum logic [1:0] {
      CDOWN = 2'd0,
      LOGO  = 2'd1,
      HEAD  = 2'd2,
      RUN   = 2'd3
   } phase_t;

   typedef logic signed [11:0] offset_t;

   // Signed horizontal offset of a lane relative to the centre lane.
   function automatic int lane_to_offset(input int lane, input int lanes, input int pitch);
      return (lane - (lanes - 1) / 2) * pitch;
   endfunction

endpackage

// File: rtl/scene_sequencer_edge_detect.sv
// One-bit registered rising-edge detector; the pulse is registered, so it
// appears one cycle after the first sample in which the input is seen high.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_d,
   output logic o_pulse
);

   logic r_q;
   logic r_pulse;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q     <= 1'b0;
         r_pulse <= 1'b0;
      end else if (i_clr) begin
         r_q     <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_q     <= i_d;
         r_pulse <= i_d & ~r_q;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/scene_sequencer.sv
// Frame-rate scene controller: countdown, logo slide, head slide, then a
// running coin track, plus edge-triggered lane steering from the L/R buttons.
module scene_sequencer
   import scene_pkg::*;
#(
   parameter  int W           = 12,
   parameter  int NUM_COINS   = 3,
   parameter  int LANES       = 3,
   parameter  int LANE_PITCH  = 100,
   parameter  int COUNTDOWN   = 5,
   parameter  int LOGO_STEP   = 30,
   parameter  int LOGO_END    = 640,
   parameter  int HEAD_START  = 180,
   parameter  int HEAD_STEP   = 17,
   parameter  int HEAD_END    = 50,
   parameter  int COIN_START  = -50,
   parameter  int COIN_WRAP   = 60,
   parameter  int COIN_BASE_X = 280,
   parameter  int COIN_SPREAD = 80,
   parameter  int COIN_BASE_Y = 40,
   parameter  int COIN_VSCALE = 6,
   localparam int LANE_W      = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                   CLK100MHZ,
   input  logic                   CPU_RESETN,
   input  logic                   vsync,
   input  logic                   restart,
   input  logic                   pause,
   input  logic                   btn_left,
   input  logic                   btn_right,
   output logic                   frame_tick,
   output logic [1:0]             phase,
   output logic [LANE_W-1:0]      lane,
   output logic [W-1:0]           logo_voffset,
   output logic [W-1:0]           head_hoffset,
   output logic [W-1:0]           head_voffset,
   output logic [NUM_COINS*W-1:0] coin_hoffset,
   output logic [W-1:0]           coin_voffset,
   output logic                   coin_wrap
);

   localparam int CNT_W  = $clog2(COUNTDOWN + 1);
   localparam int CENTRE = (LANES - 1) / 2;

   localparam logic [CNT_W-1:0]    C_CNT_INIT   = CNT_W'(COUNTDOWN);
   localparam logic [LANE_W-1:0]   C_LANE_INIT  = LANE_W'(CENTRE);
   localparam logic [LANE_W-1:0]   C_LANE_MAX   = LANE_W'(LANES - 1);
   localparam logic signed [W-1:0] C_HEAD_START = W'(HEAD_START);
   localparam logic signed [W-1:0] C_COIN_START = W'(COIN_START);

   phase_t                r_phase,     w_phase_nxt;
   logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
   logic signed [W-1:0]   r_logo,      w_logo_nxt;
   logic signed [W-1:0]   r_head_v,    w_head_v_nxt;
   logic signed [W-1:0]   r_coinpos,   w_coinpos_nxt;
   logic [LANE_W-1:0]     r_lane,      w_lane_nxt;
   logic                  r_coin_wrap, w_coin_wrap_nxt;

   logic w_frame_tick;
   logic w_left_edge;
   logic w_right_edge;
   int   w_logo_sum;
   int   w_head_diff;

   // Restart also clears the vsync history so a restart never leaves a
   // half-seen edge behind.
   edge_detect u_vsync_edge (
      .clk     (CLK100MHZ),
      .rst_n   (CPU_RESETN),
      .i_clr   (restart),
      .i_d     (vsync),
      .o_pulse (w_frame_tick)
   );

   edge_detect u_left_edge (
      .clk     (CLK100MHZ),
      .rst_n   (CPU_RESETN),
      .i_clr   (1'b0),
      .i_d     (btn_left),
      .o_pulse (w_left_edge)
   );

   edge_detect u_right_edge (
      .clk     (CLK100MHZ),
      .rst_n   (CPU_RESETN),
      .i_clr   (1'b0),
      .i_d     (btn_right),
      .o_pulse (w_right_edge)
   );

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_phase     <= CDOWN;
         r_cnt       <= C_CNT_INIT;
         r_logo      <= '0;
         r_head_v    <= C_HEAD_START;
         r_coinpos   <= C_COIN_START;
         r_lane      <= C_LANE_INIT;
         r_coin_wrap <= 1'b0;
      end else begin
         r_phase     <= w_phase_nxt;
         r_cnt       <= w_cnt_nxt;
         r_logo      <= w_logo_nxt;
         r_head_v    <= w_head_v_nxt;
         r_coinpos   <= w_coinpos_nxt;
         r_lane      <= w_lane_nxt;
         r_coin_wrap <= w_coin_wrap_nxt;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_phase_nxt     = r_phase;
      w_cnt_nxt       = r_cnt;
      w_logo_nxt      = r_logo;
      w_head_v_nxt    = r_head_v;
      w_coinpos_nxt   = r_coinpos;
      w_lane_nxt      = r_lane;
      w_coin_wrap_nxt = 1'b0;
      w_logo_sum      = int'(r_logo) + LOGO_STEP;
      w_head_diff     = int'(r_head_v) - HEAD_STEP;

      if (restart) begin
         w_phase_nxt   = CDOWN;
         w_cnt_nxt     = C_CNT_INIT;
         w_logo_nxt    = '0;
         w_head_v_nxt  = C_HEAD_START;
         w_coinpos_nxt = C_COIN_START;
         w_lane_nxt    = C_LANE_INIT;
      end else begin
         if (w_frame_tick && !pause) begin
            unique case (r_phase)
               CDOWN: begin
                  if (r_cnt == CNT_W'(1)) w_phase_nxt = LOGO;
                  else                    w_cnt_nxt   = r_cnt - CNT_W'(1);
               end
               LOGO: begin
                  if (w_logo_sum >= LOGO_END) begin
                     w_logo_nxt  = W'(LOGO_END);
                     w_phase_nxt = HEAD;
                  end else begin
                     w_logo_nxt  = W'(w_logo_sum);
                  end
               end
               HEAD: begin
                  if (w_head_diff <= HEAD_END) begin
                     w_head_v_nxt = W'(HEAD_END);
                     w_phase_nxt  = RUN;
                  end else begin
                     w_head_v_nxt = W'(w_head_diff);
                  end
               end
               RUN: begin
                  if (r_coinpos[W-1]) begin
                     w_coinpos_nxt = '0;
                  end else if (r_coinpos == W'(COIN_WRAP - 1)) begin
                     w_coinpos_nxt   = '0;
                     w_coin_wrap_nxt = 1'b1;
                  end else begin
                     w_coinpos_nxt = r_coinpos + W'(1);
                  end
               end
            endcase
         end

         // Simultaneous left and right edges cancel out.
         if ((r_phase == HEAD || r_phase == RUN) && (w_left_edge ^ w_right_edge)) begin
            if (w_left_edge) begin
               if (r_lane != '0) w_lane_nxt = r_lane - LANE_W'(1);
            end else if (r_lane != C_LANE_MAX) begin
               w_lane_nxt = r_lane + LANE_W'(1);
            end
         end
      end
   end

   assign frame_tick   = w_frame_tick;
   assign phase        = r_phase;
   assign lane         = r_lane;
   assign logo_voffset = r_logo;
   assign head_voffset = r_head_v;
   assign head_hoffset = W'(lane_to_offset(int'(r_lane), LANES, LANE_PITCH));
   assign coin_voffset = W'(COIN_BASE_Y + COIN_VSCALE * int'(r_coinpos));
   assign coin_wrap    = r_coin_wrap;

   for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_coin
      assign coin_hoffset[gi*W +: W] =
         W'(COIN_BASE_X + (gi - (NUM_COINS - 1) / 2) * (COIN_SPREAD + int'(r_coinpos)));
   end

endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
Frame-rate scene/animation controller for the game top level. It replaces the ad-hoc countdown, logo, head and coin offset logic with one parametrised block. The block runs on the system clock and is advanced by a registered vsync edge detect, not by clocking on vsync. It drives layer offset inputs (logo, head, N coins) and tracks a lane index from the L/R buttons. New behaviour over the previous logic:
- saturating end values
- coin-track wrap with a pulse
- pause and restart inputs
- N-lane edge-triggered steering

Parameters:
W, 12, signed width of every offset/position value
NUM_COINS, 3, coin replicas; must be odd
LANES, 3, lane count; must be odd and at least 1; centre lane is (LANES-1)/2
LANE_PITCH, 100, head horizontal offset per lane step
COUNTDOWN, 5, frames spent in CDOWN; must be at least 1
LOGO_STEP, 30, logo voffset increment per frame
LOGO_END, 640, logo voffset final value
HEAD_START, 180, head voffset initial value
HEAD_STEP, 17, head voffset decrement per frame
HEAD_END, 50, head voffset final value
COIN_START, -50, coin position while not running
COIN_WRAP, 60, coin position wraps to 0 on reaching this value
COIN_BASE_X, 280, centre coin hoffset
COIN_SPREAD, 80, base horizontal spacing between coins
COIN_BASE_Y, 40, coin voffset at position 0
COIN_VSCALE, 6, coin voffset per position unit

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  asynchronous active-low reset
vsync  in  1  VGA vsync; derived from CLK100MHZ, so no synchroniser is needed
restart  in  1  synchronous restart pulse
pause  in  1  level; while high, frame updates are frozen
btn_left  in  1  level, already debounced
btn_right  in  1  level, already debounced
frame_tick  out  1  one-cycle pulse on each vsync rising edge
phase  out  2  current state: 0 CDOWN, 1 LOGO, 2 HEAD, 3 RUN
lane  out  $clog2(LANES) or 1, whichever is larger  current lane index
logo_voffset  out  W  logo layer voffset
head_hoffset  out  W  head layer hoffset
head_voffset  out  W  head layer voffset
coin_hoffset  out  NUM_COINS*W  packed, coin i at bits [i*W +: W]
coin_voffset  out  W  shared voffset for all coins
coin_wrap  out  1  one-cycle pulse when the coin position wraps

Behaviour:
- Reset (CPU_RESETN low, asynchronous):
  - phase=CDOWN, cnt=COUNTDOWN
  - logo=0, head_v=HEAD_START, coinpos=COIN_START
  - lane=centre, vs_q=0, frame_tick=0, coin_wrap=0
- Restart (restart high at a clock edge): loads the same values synchronously. Restart has priority over a tick in the same cycle.
- Frame tick:
  - vs_q registers vsync.
  - frame_tick is registered: high for exactly one cycle, in the cycle after the first cycle in which vsync=1 and vs_q=0.
  - A state update happens on the edge at which frame_tick=1 and pause=0. With pause=1, ticks are still emitted but the state does not change.
- State machine (on an enabled tick):
  - CDOWN: if cnt==1, go to LOGO; otherwise cnt decrements. Exactly COUNTDOWN ticks are spent in CDOWN.
  - LOGO: logo = min(logo+LOGO_STEP, LOGO_END). When the result equals LOGO_END, go to HEAD on the same tick.
  - HEAD: head_v = max(head_v-HEAD_STEP, HEAD_END). When the result equals HEAD_END, go to RUN on the same tick.
  - RUN, coinpos<0: coinpos becomes 0.
  - RUN, coinpos==COIN_WRAP-1: coinpos becomes 0 and coin_wrap pulses high for 1 cycle.
  - RUN, otherwise: coinpos increments.
  - RUN is terminal until reset or restart.
- Lane steering:
  - Inputs are rising-edge detected on registered copies, independent of frame_tick and pause.
  - Accepted only in phase HEAD or RUN; edges in other phases are discarded.
  - Left edge: lane-1, saturating at 0. Right edge: lane+1, saturating at LANES-1.
  - Left and right edges in the same cycle: no change.
  - A held button produces a single step.
- Outputs are combinational from registered state, so they change one cycle after the updating edge.
  - logo_voffset = logo
  - head_voffset = head_v
  - head_hoffset = (lane - centre) * LANE_PITCH
  - d_i = i - (NUM_COINS-1)/2
  - coin_hoffset[i] = COIN_BASE_X + d_i*(COIN_SPREAD + coinpos)
  - coin_voffset = COIN_BASE_Y + COIN_VSCALE*coinpos
- Arithmetic: all W-bit signed, two's-complement truncation. Parameters are chosen so that no overflow occurs; the bench asserts this.

Decomposition:
- Package scene_pkg holds:
  - typedef enum logic [1:0] phase_t {CDOWN, LOGO, HEAD, RUN}
  - typedef logic signed [11:0] offset_t
  - lane-to-offset helper function
- One sub-module: edge_detect, a 1-bit registered rising-edge detector with async active-low reset. It is used for vsync, btn_left and btn_right.

Test Plan:
1. Reset, then 5 vsync pulses -> phase stays 0 through tick 4 and becomes 1 after tick 5; logo_voffset=0 throughout.
2. LOGO phase with 22 ticks -> logo_voffset is 30, 60, …, 630, then 640 on tick 22 (not 660), and phase=2.
3. HEAD phase with 8 ticks -> head_voffset is 163, 146, 129, 112, 95, 78, 61, then 50 with phase=3. The next tick gives coinpos 0, coin_hoffset={360, 280, 200} (i=2..0), coin_voffset=40.
4. RUN through 60 more ticks -> coinpos reaches 59 (coin_voffset=394), then 0 on tick 60 with coin_wrap high for exactly 1 cycle. pause=1 held for 10 ticks leaves all offsets unchanged.
5. In RUN, btn_right held 1000 cycles -> lane=2, head_hoffset=100. Three left presses -> lane=0, head_hoffset=-100 (saturated). Both pressed together -> no change. Presses in CDOWN are ignored.
6. restart asserted in the same cycle as frame_tick during RUN -> the next cycle shows phase=0, logo=0, head_v=180, lane=1. CPU_RESETN pulsed low mid-LOGO -> outputs return to reset values immediately, without waiting for a clock edge.
